// File: rtl/mem_arbiter.sv
// Three-requester arbiter (loader, instruction fetch, data) in front of a single-port
// synchronous memory with 1-cycle read latency. Loader has absolute priority; if/dm alternate.
module mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          CLK,
  input  logic          RST,

  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,

  input  logic          if_req,
  input  logic          if_we,
  input  logic [AW-1:0] if_addr,
  input  logic [DW-1:0] if_wdata,
  output logic          if_ack,

  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,

  output logic [DW-1:0] rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnLd   = 2'd1;
  localparam logic [1:0] OwnIf   = 2'd2;
  localparam logic [1:0] OwnDm   = 2'd3;

  state_e        state_q;
  logic [1:0]    owner_q;
  logic          rr_q;      // 0: favour if, 1: favour dm
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [2:0]    ack_q;     // {ld, if, dm}

  logic [2:0]    elig;
  logic [1:0]    win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  function automatic logic [2:0] owner_mask(input logic [1:0] o);
    logic [2:0] m;
    case (o)
      OwnLd:   m = 3'b100;
      OwnIf:   m = 3'b010;
      OwnDm:   m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // The owner being acked in DONE is excluded so it must re-arbitrate next time.
  always_comb begin
    elig = {ld_req, if_req, dm_req};
    if (state_q == StDone) begin
      elig = elig & ~owner_mask(owner_q);
    end
    if (elig[2]) begin
      win = OwnLd;
    end else if (elig[1] && elig[0]) begin
      win = rr_q ? OwnDm : OwnIf;
    end else if (elig[1]) begin
      win = OwnIf;
    end else if (elig[0]) begin
      win = OwnDm;
    end else begin
      win = OwnNone;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (win)
      OwnLd: begin
        sel_we    = ld_we;
        sel_addr  = ld_addr;
        sel_wdata = ld_wdata;
      end
      OwnIf: begin
        sel_we    = if_we;
        sel_addr  = if_addr;
        sel_wdata = if_wdata;
      end
      OwnDm: begin
        sel_we    = dm_we;
        sel_addr  = dm_addr;
        sel_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      owner_q  <= OwnNone;
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack_q    <= 3'b000;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack_q    <= 3'b000;
      case (state_q)
        StIdle, StDone: begin
          if (win != OwnNone) begin
            state_q  <= StAccess;
            owner_q  <= win;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            mem_en_q <= 1'b1;
            mem_we_q <= sel_we;
            // Loader grants leave the if/dm pointer alone.
            if (win == OwnIf) begin
              rr_q <= 1'b1;
            end else if (win == OwnDm) begin
              rr_q <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            owner_q <= OwnNone;
          end
        end
        StAccess: begin
          state_q <= StDone;
          ack_q   <= owner_mask(owner_q);
        end
        default: begin
          state_q <= StIdle;
          owner_q <= OwnNone;
        end
      endcase
    end
  end

  // Read data arrives from memory during DONE, one cycle after the ACCESS strobe.
  always_comb begin
    rdata = '0;
    if (state_q == StDone && !we_q) begin
      rdata = mem_rdata;
    end
  end

  assign ld_ack    = ack_q[2];
  assign if_ack    = ack_q[1];
  assign dm_ack    = ack_q[0];
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width in bits.
REQ-002 SHALL have parameter DW, default 16, meaning data width in bits.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for each requester X in {ld (loader), if (instruction fetch), dm (data access)}: X_req in 1, X_we in 1, X_addr in AW, X_wdata in DW, X_ack out 1.
REQ-006 SHALL have port rdata  output  DW  read data, shared by all requesters, qualified by the matching X_ack.
REQ-007 SHALL have memory-side ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW; memory is synchronous with 1-cycle read latency.
REQ-008 SHALL have ports busy out 1 (state != IDLE) and owner out 2 (0=none, 1=ld, 2=if, 3=dm).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-010 IDLE: if any eligible req is high, SHALL register the winner into owner and go to ACCESS; otherwise stay in IDLE.
REQ-011 ACCESS: SHALL drive mem_en=1, mem_addr/mem_we/mem_wdata from the owner's inputs for exactly one cycle, then go to DONE.
REQ-012 DONE: SHALL pulse the owner's X_ack for exactly one cycle, with rdata = mem_rdata for reads and rdata = 0 for writes.
REQ-013 DONE: SHALL arbitrate among eligible requesters excluding the current owner; on a winner go directly to ACCESS, else go to IDLE with owner=0.
REQ-014 Request-to-ack latency SHALL be 2 cycles from IDLE (req sampled at edge N, ack high during cycle N+2); back-to-back transactions from different requesters SHALL complete one every 2 cycles.
REQ-015 Requesters hold X_req, X_we, X_addr and X_wdata stable from assertion until the cycle of X_ack; the arbiter SHALL capture X_addr, X_we and X_wdata into registers at grant and drive the memory from those registers.
REQ-016 Priority SHALL be: ld absolute highest; between if and dm, round-robin via a 1-bit pointer toggled to favour the other requester after each if or dm grant.
REQ-017 ld grants SHALL NOT update the round-robin pointer; sustained ld_req may starve if/dm (permitted).
REQ-018 A requester whose req is still high in its own ack cycle SHALL be treated as a new request, eligible from the next arbitration.
REQ-019 mem_en and mem_we SHALL be 0 in IDLE and DONE; at most one X_ack SHALL be high in any cycle.
REQ-020 A requester dropping req before ack (protocol violation) SHALL NOT abort the transaction; ack is still issued.

Reset
REQ-021 RST low SHALL immediately, without waiting for CLK, force state=IDLE, owner=0, busy=0, all X_ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, and round-robin pointer favouring if.
REQ-022 Reset asserted in ACCESS or DONE SHALL abort the transaction with no ack; a write in ACCESS SHALL have mem_we removed asynchronously.
REQ-023 First arbitration SHALL occur on the first rising CLK edge after RST goes high.

Verification
REQ-024 Single read: if_req=1, if_addr=0x0003, mem[3]=0xC003 -> mem_en=1 with mem_addr=0x0003 in cycle 1, if_ack=1 with rdata=0xC003 in cycle 2, then IDLE.
REQ-025 Write: dm_req=1, dm_we=1, dm_addr=0x0010, dm_wdata=0x1234 -> single mem_we pulse, dm_ack in next cycle, subsequent if read of 0x0010 returns 0x1234.
REQ-026 Contention: if_req and dm_req both held continuously from reset -> acks in order if, dm, if, dm, 2 cycles apart, no idle cycle between them.
REQ-027 Loader priority: ld_req, if_req and dm_req all asserted in IDLE -> ld_ack first; if and dm then served in round-robin order with the pointer unchanged by the ld grant.
REQ-028 Reset mid-write: RST low during the ACCESS cycle of a dm write -> mem_we falls immediately, no dm_ack, owner=0; after release a new request completes normally.
REQ-029 Bench SHALL check throughout: at most one ack high per cycle, mem_we=1 only in ACCESS, busy high exactly when state != IDLE.
